// File: rtl/cim_mul_pkg.sv
// cim_mul_pkg
//   Shared types and helpers for the CIM Booth multiplier sequencer:
//   FSM state encoding, radix-4 Booth digit encoding and the window decoder.
package cim_mul_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = DATA_W_DEF / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    COMP,
    WB,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_e;

  // Window is {B[2i+1], B[2i], B[2i-1]}.
  function automatic booth_e booth_digit(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return P1;
      3'b011:         return P2;
      3'b100:         return M2;
      3'b101, 3'b110: return M1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/cim_booth_enc.sv
// cim_booth_enc
//   Combinational radix-4 Booth partial-product generator.
//   a   : signed multiplicand, DATA_W bits
//   win : Booth window {B[2i+1], B[2i], B[2i-1]}
//   pp  : digit*a, two's complement, DATA_W+2 bits (holds -2*min(a))
module cim_booth_enc
  import cim_mul_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [2:0]        win,
  output logic [DATA_W+1:0] pp
);

  logic [DATA_W+1:0] a_x1;
  logic [DATA_W+1:0] a_x2;

  assign a_x1 = {{2{a[DATA_W-1]}}, a};
  assign a_x2 = {a_x1[DATA_W:0], 1'b0};

  always_comb begin
    pp = '0;
    case (booth_digit(win))
      P1:      pp = a_x1;
      P2:      pp = a_x2;
      M1:      pp = -a_x1;
      M2:      pp = -a_x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/cim_booth_mul_seq.sv
// cim_booth_mul_seq
//   Sequences one CIM SRAM macro through a radix-4 Booth signed multiply:
//   DATA_W/2 passes of precharge / compute / writeback, Horner-accumulated
//   in the macro across ping-pong accumulator rows.
//   Host side : CLK, RSTn, start, a_in, b_in -> busy, done, product, golden, err
//   Macro side: ARR_OUT -> WWL, RWL, WBL/WBLb, RWWL, RWBL/RWBLb, F, MUL, Shift, NShift
//
//   state | meaning
//   IDLE  | waiting for start, operands latched on accept
//   LOAD  | clear accumulator row 0
//   PRE   | precharge, write Booth partial product for digit i
//   COMP  | read acc row r, add PP, shift by 2 unless last digit
//   WB    | write result into the next acc row, step digit
//   DONE  | capture macro readout, pulse done next cycle
module cim_booth_mul_seq
  import cim_mul_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ROWS     = 2,
  parameter int CHECK_EN = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a_in,
  input  logic [DATA_W-1:0]     b_in,
  input  logic [2*DATA_W-1:0]   ARR_OUT,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product,
  output logic [2*DATA_W-1:0]   golden,
  output logic                  err,
  output logic [ROWS-1:0]       WWL,
  output logic [ROWS-1:0]       RWL,
  output logic [DATA_W+1:0]     WBL,
  output logic [DATA_W+1:0]     WBLb,
  output logic                  RWWL,
  output logic [DATA_W+1:0]     RWBL,
  output logic [DATA_W+1:0]     RWBLb,
  output logic                  F,
  output logic                  MUL,
  output logic                  Shift,
  output logic                  NShift
);

  localparam int N  = DATA_W / 2;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int OW = 2 * DATA_W;

  state_e              state;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [IW-1:0]       idx;
  logic [RW-1:0]       row;
  logic [RW-1:0]       row_nxt;
  logic [IW-1:0]       i_sel;
  logic [DATA_W:0]     b_ext;
  logic [2:0]          win;
  logic [DATA_W+1:0]   pp;
  logic signed [OW-1:0] a_sx;
  logic signed [OW-1:0] b_sx;
  logic signed [OW-1:0] prod_full;

  // PP is registered on entry to PRE: from LOAD the digit is already N-1,
  // from WB it is the one about to be stepped to.
  assign i_sel = (state == WB) ? idx - IW'(1) : idx;
  assign b_ext = {b_r, 1'b0};
  assign win   = b_ext[{i_sel, 1'b0} +: 3];

  assign row_nxt = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);

  assign a_sx      = {{DATA_W{a_in[DATA_W-1]}}, a_in};
  assign b_sx      = {{DATA_W{b_in[DATA_W-1]}}, b_in};
  assign prod_full = a_sx * b_sx;

  assign WBLb  = ~WBL;
  assign RWBLb = ~RWBL;

  cim_booth_enc #(.DATA_W(DATA_W)) u_enc (
    .a   (a_r),
    .win (win),
    .pp  (pp)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      row     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      golden  <= '0;
      err     <= 1'b0;
      WWL     <= '0;
      RWL     <= '0;
      WBL     <= '0;
      RWWL    <= 1'b0;
      RWBL    <= '0;
      F       <= 1'b0;
      MUL     <= 1'b0;
      Shift   <= 1'b0;
      NShift  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a_in;
            b_r    <= b_in;
            golden <= (CHECK_EN != 0) ? prod_full : '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            idx    <= IW'(N - 1);
            row    <= '0;
            WWL    <= ROWS'(1);
            WBL    <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          WWL   <= '0;
          F     <= 1'b1;
          RWWL  <= 1'b1;
          RWBL  <= pp;
          state <= PRE;
        end
        PRE: begin
          F      <= 1'b0;
          RWWL   <= 1'b0;
          RWBL   <= '0;
          RWL    <= ROWS'(1) << row;
          MUL    <= 1'b1;
          Shift  <= (idx != '0);
          NShift <= (idx == '0);
          state  <= COMP;
        end
        COMP: begin
          RWL    <= '0;
          MUL    <= 1'b0;
          Shift  <= 1'b0;
          NShift <= 1'b0;
          WWL    <= ROWS'(1) << row_nxt;
          row    <= row_nxt;
          state  <= WB;
        end
        WB: begin
          WWL <= '0;
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx   <= idx - IW'(1);
            F     <= 1'b1;
            RWWL  <= 1'b1;
            RWBL  <= pp;
            state <= PRE;
          end
        end
        DONE: begin
          product <= ARR_OUT;
          done    <= 1'b1;
          busy    <= 1'b0;
          err     <= (CHECK_EN != 0) && (ARR_OUT != golden);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
